ps2_paddle_receiver: RTL and testbench

- Receives PS/2 keyboard frames (scan code set 2) and decodes make/break sequences into held-key levels for both paddles.
- Drop-in alternative to the four paddle push-buttons: outputs feed the existing debouncer inputs p1p/p1m/p2p/p2m and use the same active-low button convention (0 = pressed).
- Sits between the board PS/2 pins and the debouncers in top; runs on the system clk.

---
 rtl/ps2_paddle_receiver.sv | 148 ++++++++++++++
 tb/tb_ps2_paddle_receiver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_paddle_receiver.sv
// ps2_paddle_receiver: PS/2 set-2 receiver driving active-low paddle buttons.
// Define PS2_GAME_KEYS_EN to add serve_n (Space) and start_n (Enter).
module ps2_paddle_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       p1p,
  output logic       p1m,
  output logic       p2p,
  output logic       p2m,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
`ifdef PS2_GAME_KEYS_EN
  ,
  output logic       serve_n,
  output logic       start_n
`endif
);
`ifdef PS2_GAME_KEYS_EN
  localparam int NK = 6;
`else
  localparam int NK = 4;
`endif
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] clk_sync_q, dat_sync_q;
  logic flt_q, flt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d, code_q, code_d;
  logic par_q, par_d, valid_q, valid_d, err_q, err_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic [NK-1:0] keys_q, keys_d, hit;
  logic [3:0] pad_hit;
  logic diff, flip, strobe, din, timeout;
  assign din = dat_sync_q[1];
  assign diff = clk_sync_q[1] != flt_q;
  assign flip = diff && fcnt_q == FW'(FILTER_LEN - 1);
  assign fcnt_d = (!diff || flip) ? '0 : fcnt_q + 1'b1;
  assign flt_d = flip ? ~flt_q : flt_q;
  assign strobe = flip && flt_q;
  assign timeout = state_q != IDLE && !strobe && tcnt_q == TW'(TIMEOUT - 1);
  assign tcnt_d = (state_q == IDLE || strobe) ? '0 : tcnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sr_d = sr_q;
    par_d = par_q;
    code_d = code_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err_d = 1'b1;
    end else if (strobe)
      case (state_q)
        IDLE: if (!din) begin
          state_d = DATA;
          bit_d = '0;
        end
        DATA: begin
          sr_d = {din, sr_q[7:1]};
          bit_d = bit_q + 1'b1;
          state_d = bit_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d = din;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          valid_d = din && ^{sr_q, par_q};
          err_d = !valid_d;
          code_d = valid_d ? sr_q : code_q;
        end
      endcase
  end
  assign pad_hit = {ext_q && code_q == 8'h72, ext_q && code_q == 8'h75,
                    !ext_q && code_q == 8'h1B, !ext_q && code_q == 8'h1D};
`ifdef PS2_GAME_KEYS_EN
  assign hit = {!ext_q && code_q == 8'h5A, !ext_q && code_q == 8'h29, pad_hit};
`else
  assign hit = pad_hit;
`endif
  // a mapped key output takes the break flag: break releases (1), make presses (0)
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    keys_d = keys_q;
    if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (valid_q) begin
      ext_d = code_q == 8'hE0 || (ext_q && code_q == 8'hF0);
      brk_d = code_q == 8'hF0 || (brk_q && code_q == 8'hE0);
      keys_d = (keys_q & ~hit) | (hit & {NK{brk_q}});
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      flt_q <= 1'b1;
      fcnt_q <= '0;
      tcnt_q <= '0;
      state_q <= IDLE;
      bit_q <= '0;
      sr_q <= '0;
      par_q <= 1'b0;
      code_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      keys_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      flt_q <= flt_d;
      fcnt_q <= fcnt_d;
      tcnt_q <= tcnt_d;
      state_q <= state_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      par_q <= par_d;
      code_q <= code_d;
      valid_q <= valid_d;
      err_q <= err_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      keys_q <= keys_d;
    end
  assign {p2m, p2p, p1m, p1p} = keys_q[3:0];
`ifdef PS2_GAME_KEYS_EN
  assign {start_n, serve_n} = keys_q[5:4];
`endif
  assign code = code_q;
  assign code_valid = valid_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_ps2_paddle_receiver.sv
// tb_ps2_paddle_receiver: directed and random PS/2 frames against a byte-level key model.
module tb_ps2_paddle_receiver;
  localparam int TO = 300;
  localparam int H = 12;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic p1p, p1m, p2p, p2m, code_valid, frame_err;
  logic [7:0] code;
`ifdef PS2_GAME_KEYS_EN
  logic serve_n, start_n;
`endif
  int checks = 0, errors = 0;
  int cyc = 0, last_fall = 0, err_cyc = 0;
  int nvalid = 0, nerr = 0, nwide = 0, nlate = 0;
  int exp_valid = 0, exp_err = 0;
  logic [5:0] m_keys = 6'h3F;
  logic [7:0] m_code = 8'h00;
  bit m_ext = 0, m_brk = 0;
  logic pv = 1'b0, pe = 1'b0, pr = 1'b1;
  logic [5:0] pk = 6'h3F;
  logic [8:0] ktab [10] = '{9'h01D, 9'h01B, 9'h175, 9'h172, 9'h01C,
                            9'h16B, 9'h029, 9'h05A, 9'h11D, 9'h075};
  ps2_paddle_receiver #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .p1p(p1p), .p1m(p1m), .p2p(p2p), .p2m(p2m),
    .code(code), .code_valid(code_valid), .frame_err(frame_err)
`ifdef PS2_GAME_KEYS_EN
    , .serve_n(serve_n), .start_n(start_n)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [5:0] obs_keys();
`ifdef PS2_GAME_KEYS_EN
    return {start_n, serve_n, p2m, p2p, p1m, p1p};
`else
    return {2'b11, p2m, p2p, p1m, p1p};
`endif
  endfunction
  always @(negedge clk) begin
    if (code_valid) nvalid++;
    if (frame_err) begin
      nerr++;
      err_cyc = cyc;
    end
    if ((code_valid && pv) || (frame_err && pe)) nwide++;
    if (obs_keys() != pk && !pv && !pr) nlate++;
    pv = code_valid;
    pe = frame_err;
    pk = obs_keys();
    pr = rst;
  end
  function automatic int key_idx(bit e, logic [7:0] b);
    case ({e, b})
      9'h01D: return 0;
      9'h01B: return 1;
      9'h175: return 2;
      9'h172: return 3;
`ifdef PS2_GAME_KEYS_EN
      9'h029: return 4;
      9'h05A: return 5;
`endif
      default: return -1;
    endcase
  endfunction
  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = key_idx(m_ext, b);
      if (k >= 0) m_keys[k] = m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic v);
    ps2_data = v;
    wait_cyc(H / 2);
    ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(H);
    ps2_clk = 1'b1;
    wait_cyc(H / 2);
  endtask
  task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
  endtask
  // mode 0 good frame, 1 parity error, 2 stop error
  task automatic send_and_check(input logic [7:0] b, input int mode, input string tag);
    send_frame(b, 11, mode == 1, mode == 2);
    wait_cyc(4);
    if (mode != 0) begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
    end else begin
      exp_valid++;
      m_code = b;
      model_byte(b);
    end
    check({tag, "_keys"}, 32'(obs_keys()), 32'(m_keys));
    check({tag, "_code"}, 32'(code), 32'(m_code));
    check({tag, "_nvalid"}, nvalid, exp_valid);
    check({tag, "_nerr"}, nerr, exp_err);
  endtask
  initial begin
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    check("rst_keys", 32'(obs_keys()), 32'h3F);
    check("rst_code", 32'(code), 32'h00);
    check("rst_valid", 32'(code_valid), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    send_and_check(8'h1D, 0, "w_make");
    check("w_p1p", 32'(p1p), 32'h0);
    check("w_others", 32'({p1m, p2p, p2m}), 32'h7);
    send_and_check(8'hE0, 0, "up_e0");
    send_and_check(8'h75, 0, "up_make");
    check("up_p2p_low", 32'(p2p), 32'h0);
    send_and_check(8'hE0, 0, "up_e0b");
    send_and_check(8'hF0, 0, "up_f0");
    send_and_check(8'h75, 0, "up_break");
    check("up_p2p_high", 32'(p2p), 32'h1);
    send_and_check(8'h1B, 1, "s_badpar");
    check("s_badpar_p1m", 32'(p1m), 32'h1);
    check("s_badpar_code", 32'(code), 32'h75);
    send_frame(8'h1B, 7, 0, 0);
    wait_cyc(TO + 30);
    exp_err++;
    m_ext = 0;
    m_brk = 0;
    check("to_nerr", nerr, exp_err);
    check("to_nvalid", nvalid, exp_valid);
    check("to_window", 32'((err_cyc - last_fall) >= TO + 8 && (err_cyc - last_fall) <= TO + 12), 32'h1);
    send_and_check(8'h1B, 0, "s_make");
    check("s_p1m", 32'(p1m), 32'h0);
    ps2_data = 1'b0;
    for (int g = 0; g < 6; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
    wait_cyc(TO + 20);
    check("glitch_nvalid", nvalid, exp_valid);
    check("glitch_nerr", nerr, exp_err);
    check("glitch_keys", 32'(obs_keys()), 32'(m_keys));
    send_and_check(8'h1C, 0, "glitch_after");
    send_frame(8'hF0, 4, 0, 0);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    m_keys = 6'h3F;
    m_code = 8'h00;
    m_ext = 0;
    m_brk = 0;
    wait_cyc(TO + 20);
    check("abort_keys", 32'(obs_keys()), 32'h3F);
    check("abort_code", 32'(code), 32'h00);
    check("abort_nvalid", nvalid, exp_valid);
    check("abort_nerr", nerr, exp_err);
    send_and_check(8'h1B, 0, "abort_s");
    check("abort_s_only", 32'(obs_keys()), 32'h3D);
    for (int n = 0; n < 30; n++) begin
      logic [8:0] k;
      bit b;
      k = ktab[$urandom_range(0, 9)];
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) send_and_check(8'($urandom), int'($urandom_range(1, 2)), "rnd_bad");
      if (k[8]) send_and_check(8'hE0, 0, "rnd_e0");
      if (b) send_and_check(8'hF0, 0, "rnd_f0");
      send_and_check(k[7:0], 0, "rnd_key");
    end
    check("pulse_width", nwide, 0);
    check("key_latency", nlate, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
